seq_cmp_ctrl: RTL
=================

SEQ_CMP_CTRL -- requirements
Module: seq_cmp_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (>=1).
REQ-002 SHALL have parameter CHUNK, default 4, bits compared per cycle (1..WIDTH); NCHUNK = ceil(WIDTH/CHUNK).
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port ARST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port IN_VALID  input  1  request present.
REQ-006 SHALL have port IN_READY  output  1  block accepts a request.
REQ-007 SHALL have port A  input  WIDTH  left operand.
REQ-008 SHALL have port B  input  WIDTH  right operand.
REQ-009 SHALL have port SIGNED  input  1  operands are two's complement.
REQ-010 SHALL have port OP  input  2  00=lt, 01=le, 10=gt, 11=ge (A op B).
REQ-011 SHALL have port OUT_VALID  output  1  result present.
REQ-012 SHALL have port OUT_READY  input  1  consumer accepts result.
REQ-013 SHALL have port Y  output  1  comparison result.
REQ-014 SHALL have port NCMP  output  clog2(NCHUNK+1)  chunks examined for current result.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; IN_READY=1 only in IDLE, OUT_VALID=1 only in DONE.
REQ-016 SHALL accept a request on a CLK edge in IDLE with IN_VALID=1, then enter RUN.
REQ-017 SHALL, on accept, map lt/le to gt/ge by swapping A and B, and set CI=1 for le/ge, CI=0 for lt/gt.
REQ-018 SHALL extend both operands to NCHUNK*CHUNK bits: sign-extend if SIGNED=1, zero-extend otherwise.
REQ-019 SHALL, if SIGNED=1, invert the MSB of both extended operands so an unsigned compare yields the signed order.
REQ-020 SHALL hold chunk index IDX (NCHUNK-1 on accept) and compare chunks MSB-first, one chunk per RUN cycle.
REQ-021 SHALL, in RUN, when chunk IDX of the operands differs, set Y=(chunkA>chunkB unsigned) and enter DONE (early exit).
REQ-022 SHALL, in RUN, when chunks are equal and IDX=0, set Y=CI and enter DONE.
REQ-023 SHALL, in RUN, when chunks are equal and IDX>0, decrement IDX and stay in RUN.
REQ-024 SHALL increment NCMP once per RUN cycle from 0 at accept; NCMP is in 1..NCHUNK in DONE.
REQ-025 SHALL give latency k+1 edges from accept to OUT_VALID=1, k = chunks examined.
REQ-026 SHALL hold Y and NCMP stable in DONE until an edge with OUT_READY=1, then enter IDLE.
REQ-027 SHALL ignore IN_VALID, A, B, SIGNED and OP outside IDLE; captured values are not altered mid-operation.
REQ-028 SHALL not accept a new request on the DONE->IDLE edge; earliest accept is the following edge.

Reset
REQ-029 SHALL, while ARST=1, force state IDLE, IN_READY=1, OUT_VALID=0, Y=0, NCMP=0, IDX=0, independent of CLK.
REQ-030 SHALL, on ARST during RUN or DONE, discard the operation with no OUT_VALID pulse.

Verification
REQ-031 WIDTH=32 CHUNK=4 unsigned gt, A=0x80000000, B=0x7FFFFFFF -> Y=1, NCMP=1, OUT_VALID 2 edges after accept.
REQ-032 ge and gt with A=B=0x12345678 -> ge Y=1, gt Y=0, NCMP=8, OUT_VALID 9 edges after accept.
REQ-033 lt A=0xFFFFFFFF, B=0x00000001: SIGNED=1 -> Y=1; SIGNED=0 -> Y=0; le A=5,B=5 -> Y=1, NCMP=8.
REQ-034 WIDTH=10 CHUNK=4 signed gt A=0x200 (-512), B=0x1FF (+511) -> Y=0, NCMP=1 (extended MSB chunk differs).
REQ-035 OUT_READY low 3 cycles in DONE -> Y, NCMP, OUT_VALID=1 stable, IN_READY=0; IN_VALID pulses ignored; accept after release.
REQ-036 ARST pulse in RUN step 3 -> IN_READY=1, OUT_VALID=0 at once; next request completes correctly.

Source files
------------

// File: rtl/seq_cmp_ctrl.sv
// Multi-cycle magnitude comparator. It scans CHUNK-bit slices of the operands MSB-first
// and stops at the first slice that differs.
module seq_cmp_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 4
) (
   input  logic                                          CLK,
   input  logic                                          ARST,
   input  logic                                          IN_VALID,
   output logic                                          IN_READY,
   input  logic [WIDTH-1:0]                              A,
   input  logic [WIDTH-1:0]                              B,
   input  logic                                          SIGNED,
   input  logic [1:0]                                    OP,
   output logic                                          OUT_VALID,
   input  logic                                          OUT_READY,
   output logic                                          Y,
   output logic [$clog2((WIDTH+CHUNK-1)/CHUNK+1)-1:0]    NCMP
);

   localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int unsigned EXTW   = NCHUNK * CHUNK;
   localparam int unsigned NW     = $clog2(NCHUNK + 1);
   localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [EXTW-1:0]   opa_q, opa_d, opb_q, opb_d;
   logic              ci_q, ci_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [NW-1:0]     ncmp_q, ncmp_d;
   logic              y_q, y_d;
   logic              in_ready_q, out_valid_q;

   logic [EXTW-1:0]   ext_a, ext_b;
   logic [CHUNK-1:0]  chunk_a, chunk_b;
   logic              chunk_ne, last_chunk;

   // Sign/zero-extend to a whole number of chunks. For signed operands the MSB is
   // flipped so that an unsigned compare gives the two's-complement order.
   function automatic logic [EXTW-1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
      logic [EXTW-1:0] r;
      r             = {EXTW{sgn & v[WIDTH-1]}};
      r[WIDTH-1:0]  = v;
      r[EXTW-1]     = r[EXTW-1] ^ sgn;
      return r;
   endfunction

   assign ext_a      = extend(A, SIGNED);
   assign ext_b      = extend(B, SIGNED);
   assign chunk_a    = opa_q[EXTW-1 -: CHUNK];
   assign chunk_b    = opb_q[EXTW-1 -: CHUNK];
   assign chunk_ne   = (chunk_a != chunk_b);
   assign last_chunk = (idx_q == '0);

   // State register
   always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (IN_VALID)                 state_d = RUN;
         RUN:     if (chunk_ne || last_chunk)   state_d = DONE;
         DONE:    if (OUT_READY)                state_d = IDLE;
         default:                               state_d = IDLE;
      endcase
   end

   // Datapath and result next values. lt/le are turned into gt/ge by swapping the
   // operands, and ci supplies the answer when every chunk compares equal.
   always_comb begin
      opa_d  = opa_q;
      opb_d  = opb_q;
      ci_d   = ci_q;
      idx_d  = idx_q;
      ncmp_d = ncmp_q;
      y_d    = y_q;
      case (state_q)
         IDLE: begin
            if (IN_VALID) begin
               opa_d  = OP[1] ? ext_a : ext_b;
               opb_d  = OP[1] ? ext_b : ext_a;
               ci_d   = OP[0];
               idx_d  = IW'(NCHUNK - 1);
               ncmp_d = '0;
               y_d    = 1'b0;
            end
         end
         RUN: begin
            ncmp_d = ncmp_q + NW'(1);
            if (chunk_ne) begin
               y_d = (chunk_a > chunk_b);
            end else if (last_chunk) begin
               y_d = ci_q;
            end else begin
               idx_d = idx_q - IW'(1);
               opa_d = opa_q << CHUNK;
               opb_d = opb_q << CHUNK;
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) begin
         opa_q       <= '0;
         opb_q       <= '0;
         ci_q        <= 1'b0;
         idx_q       <= '0;
         ncmp_q      <= '0;
         y_q         <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         ci_q        <= ci_d;
         idx_q       <= idx_d;
         ncmp_q      <= ncmp_d;
         y_q         <= y_d;
         in_ready_q  <= (state_d == IDLE);
         out_valid_q <= (state_d == DONE);
      end
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = out_valid_q;
   assign Y         = y_q;
   assign NCMP      = ncmp_q;

endmodule
